// File: rtl/rd_burst_master_if.sv
// Request / memory / response signal bundle for rd_burst_master.
interface rd_burst_master_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;

  // Seen from the burst master
  modport master (
    input  req_valid, req_addr, mem_rdata,
    output req_ready, rd, addr, resp_valid, resp_data
  );

  // Seen from the user / memory side
  modport slave (
    output req_valid, req_addr, mem_rdata,
    input  req_ready, rd, addr, resp_valid, resp_data
  );
endinterface

// File: rtl/rd_burst_master.sv
// Queues read requests and issues each as a two-cycle rd strobe with a stable
// address, followed by one gap cycle; returned data is presented as a one-cycle
// response strobe.
module rd_burst_master #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  rd_burst_master_if.master        bus,
  output logic                     busy
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRd1, StRd2, StGap} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fifo_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              full, empty, push, pop;

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);
  // Ready ignores a same-cycle pop so it depends on the count alone
  assign push  = bus.req_valid && !full;

  assign bus.req_ready  = !full;
  assign bus.rd         = rd_q;
  assign bus.addr       = addr_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign busy           = (state_q != StIdle) || !empty;

  // FSM next state, read launch and response capture
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    addr_d       = addr_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    unique case (state_q)
      StIdle, StGap: begin
        // ce only matters here, so a burst in flight always completes
        if (!empty && ce) begin
          state_d = StRd1;
          pop     = 1'b1;
          addr_d  = fifo_q[rptr_q];
        end else begin
          state_d = StIdle;
        end
      end
      StRd1: state_d = StRd2;
      StRd2: begin
        state_d      = StGap;
        resp_valid_d = 1'b1;
        resp_data_d  = bus.mem_rdata;
      end
      default: state_d = StIdle;
    endcase
    rd_d = (state_d == StRd1) || (state_d == StRd2);
  end

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // FIFO storage; contents need no reset since the count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= bus.req_addr;
    end
  end

  // State and output registers; reset aborts any read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end
endmodule

// File: tb/tb_rd_burst_master.sv
// Directed bench for rd_burst_master with a queue-based reference model.
module tb_rd_burst_master;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  logic busy;

  rd_burst_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rd_burst_master #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Memory: correct data only in the second rd cycle, inverted data otherwise
  logic [DW-1:0] mem_tbl [256];
  logic          rd_d1 = 1'b0;
  always @(posedge clk) rd_d1 <= bus.rd;
  assign bus.mem_rdata = (bus.rd && rd_d1) ? mem_tbl[bus.addr] : ~mem_tbl[bus.addr];

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: age counts edges since the last read started (saturating).
  // Ages 1,2 are the rd cycles, 3 is the response/gap cycle, 4 means idle.
  logic [AW-1:0] q[$];
  int            age = 4;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_rd, m_rv, m_busy, m_ready;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      age     = 4;
      m_addr  = '0;
      m_rdata = '0;
    end else begin
      bit can_push;
      bit start;
      can_push = bus.req_valid && (q.size() < DEPTH);
      start    = (age >= 3) && (q.size() != 0) && ce;
      if (age == 2) m_rdata = mem_tbl[m_addr];
      if (start) begin
        m_addr = q.pop_front();
        age    = 1;
      end else if (age < 4) begin
        age++;
      end
      if (can_push) q.push_back(bus.req_addr);
    end
    m_rd    = (age == 1) || (age == 2);
    m_rv    = (age == 3);
    m_busy  = (age <= 3) || (q.size() != 0);
    m_ready = (q.size() < DEPTH);
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd", 32'(bus.rd), 32'(m_rd));
      chk("addr", 32'(bus.addr), 32'(m_addr));
      chk("resp_valid", 32'(bus.resp_valid), 32'(m_rv));
      chk("resp_data", 32'(bus.resp_data), 32'(m_rdata));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("req_ready", 32'(bus.req_ready), 32'(m_ready));
    end
  end

  initial begin
    int guard;
    int nresp;
    for (int i = 0; i < 256; i++) mem_tbl[i] = DW'($urandom);
    mem_tbl[8'h3C] = 8'hA5;
    rst = 1'b1;
    ce = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset rd", 32'(bus.rd), 32'd0);
    chk("reset addr", 32'(bus.addr), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset resp_data", 32'(bus.resp_data), 32'd0);

    // Single read at 0x3C
    ce = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr = 8'h3C;
    step();
    bus.req_valid = 1'b0;
    chk("single rd before start", 32'(bus.rd), 32'd0);
    step();
    chk("single rd cycle1", 32'(bus.rd), 32'd1);
    chk("single addr", 32'(bus.addr), 32'h3C);
    step();
    chk("single rd cycle2", 32'(bus.rd), 32'd1);
    step();
    chk("single rd end", 32'(bus.rd), 32'd0);
    chk("single resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("single resp_data", 32'(bus.resp_data), 32'hA5);
    step();
    chk("single resp pulse end", 32'(bus.resp_valid), 32'd0);
    chk("single resp_data held", 32'(bus.resp_data), 32'hA5);
    chk("single idle busy", 32'(busy), 32'd0);

    // Burst of four back-to-back reads
    nresp = 0;
    for (int k = 0; k <= 12; k++) begin
      bus.req_valid = (k < 4);
      bus.req_addr = 8'(8'h10 + k);
      step();
      bus.req_valid = 1'b0;
      if (k >= 1) chk("burst rd pattern", 32'(bus.rd), 32'((k % 3) != 0));
      if (k >= 1 && (k % 3) == 1) chk("burst addr", 32'(bus.addr), 32'(8'h10 + (k - 1) / 3));
      if (bus.resp_valid) nresp++;
    end
    chk("burst resp count", 32'(nresp), 32'd4);
    step();
    step();

    // ce gating
    ce = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr = 8'h20;
    step();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("gated rd", 32'(bus.rd), 32'd0);
      chk("gated busy", 32'(busy), 32'd1);
    end
    ce = 1'b1;
    step();
    chk("ce rise rd", 32'(bus.rd), 32'd1);
    chk("ce rise addr", 32'(bus.addr), 32'h20);
    ce = 1'b0;
    step();
    chk("ce drop rd held", 32'(bus.rd), 32'd1);
    step();
    chk("ce drop rd end", 32'(bus.rd), 32'd0);
    chk("ce drop resp", 32'(bus.resp_valid), 32'd1);
    step();

    // Full FIFO with ce low
    for (int k = 0; k < 4; k++) begin
      bus.req_valid = 1'b1;
      bus.req_addr = 8'(8'h30 + k);
      step();
    end
    chk("full req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_addr = 8'h34;
    step();
    chk("full 5th held", 32'(bus.req_ready), 32'd0);
    ce = 1'b1;
    step();
    chk("full first pop rd", 32'(bus.rd), 32'd1);
    chk("full first pop addr", 32'(bus.addr), 32'h30);
    chk("full ready after pop", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    repeat (16) step();
    chk("full drained", 32'(busy), 32'd0);

    // Reset during RD2 with two entries queued
    bus.req_valid = 1'b1;
    bus.req_addr = 8'h40;
    step();
    bus.req_addr = 8'h41;
    step();
    bus.req_addr = 8'h42;
    step();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort rd", 32'(bus.rd), 32'd0);
    chk("abort resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort addr", 32'(bus.addr), 32'd0);
    step();
    chk("abort no resp", 32'(bus.resp_valid), 32'd0);

    // Random requests with random ce gaps
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr = AW'($urandom);
      ce = 1'b1;
      guard = 0;
      while (!bus.req_ready && guard < 40) begin
        step();
        guard++;
      end
      if (guard >= 40) begin
        n_total++;
        $display("FAIL accept timeout: got ready 0 expected 1 at %0t", $time);
      end
      step();
      bus.req_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        ce = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    ce = 1'b1;
    repeat (40) step();
    chk("random drained", 32'(busy), 32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
